// File: rtl/train_timer.sv
// Millisecond countdown timer: loads a 19-bit ms duration, counts it down with a
// TICKS_PER_MS prescaler and pulses expired for one cycle. Optional macro: TIMER_PAUSE_EN (adds hold).
module train_timer #(
    parameter int TICKS_PER_MS = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [18:0] t,
    input  logic        start,
`ifdef TIMER_PAUSE_EN
    input  logic        hold,
`endif
    output logic        busy,
    output logic        expired,
    output logic [18:0] remaining
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_MS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         r_state;
    logic [PW-1:0]  r_pre;
    logic [18:0]    r_remaining;
    logic           w_wrap;
    logic           w_hold;

    assign w_wrap = (r_pre == PRE_MAX);
`ifdef TIMER_PAUSE_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // Countdown state machine: start overrides everything, RUN advances the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pre       <= '0;
            r_remaining <= 19'd0;
        end else if (start) begin
            r_pre <= '0;
            if (t != 19'd0) begin
                r_remaining <= t;
                r_state     <= RUN;
            end else begin
                r_remaining <= 19'd0;
                r_state     <= DONE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                RUN: begin
                    if (w_hold) begin
                        r_state <= RUN;
                    end else if (w_wrap) begin
                        r_pre       <= '0;
                        r_remaining <= r_remaining - 19'd1;
                        if (r_remaining == 19'd1) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= RUN;
                        end
                    end else begin
                        r_pre <= r_pre + PW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    // An illegal encoding recovers to a clean idle timer.
                    r_state     <= IDLE;
                    r_pre       <= '0;
                    r_remaining <= 19'd0;
                end
            endcase
        end
    end

    assign busy      = (r_state == RUN);
    assign expired   = (r_state == DONE);
    assign remaining = r_remaining;

endmodule
